// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

    localparam int MAX_N_OUT = 32;
    localparam int MAX_SEL_W = $clog2(MAX_N_OUT);

    typedef enum logic {
        HEAD,
        PKT
    } state_e;

    // Bit ch of the one-hot decode of sel; used per channel to build the unicast mask.
    function automatic logic onehot_bit(input logic [MAX_SEL_W-1:0] sel, input int unsigned ch);
        return (32'(sel) == ch);
    endfunction

endpackage

// File: rtl/out_reg_slice.sv
// One-entry output register: shared data/last plus a per-channel pending mask
// that clears bit by bit as each targeted consumer takes the beat.
module out_reg_slice #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              load_last_i,
    input  logic [N_OUT-1:0]  load_mask_i,
    input  logic [N_OUT-1:0]  m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic [N_OUT-1:0]  m_valid_o,
    output logic              in_ready_o,
    output logic              occupied_o
);

    logic [N_OUT-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [N_OUT-1:0]  remain;

    // Channels still owed the beat after this edge; empty also means "free".
    assign remain     = pend_q & ~m_ready_i;
    assign in_ready_o = (remain == '0);
    assign occupied_o = (pend_q != '0);
    assign m_valid_o  = pend_q;
    assign m_data_o   = data_q;
    assign m_last_o   = last_q;

    always_comb begin
        pend_d = remain;
        data_d = data_q;
        last_d = last_q;
        if (load_i) begin
            pend_d = load_mask_i;
            data_d = load_data_i;
            last_d = load_last_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-packet destination lock,
// broadcast, and drop-with-error for out-of-range selects.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic [SEL_W-1:0]  s_sel,
    input  logic              s_bcast,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [N_OUT-1:0]  m_valid,
    input  logic [N_OUT-1:0]  m_ready,
    output logic              err_sel,
    output logic              busy
);

    localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] dest_sel_q, dest_sel_d;
    logic             dest_bcast_q, dest_bcast_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0]     eff_sel;
    logic                 eff_bcast;
    logic [MAX_SEL_W-1:0] sel_ext;
    logic                 sel_invalid;
    logic                 accept;
    logic                 load;
    logic [N_OUT-1:0]     load_mask;
    logic                 occupied;

    // Head beats route on the live select; later beats on the latched one.
    assign eff_sel     = (state_q == HEAD) ? s_sel   : dest_sel_q;
    assign eff_bcast   = (state_q == HEAD) ? s_bcast : dest_bcast_q;
    assign sel_ext     = MAX_SEL_W'(eff_sel);
    assign sel_invalid = !eff_bcast && ({1'b0, eff_sel} >= N_OUT_L);
    assign accept      = s_valid && s_ready;
    assign load        = accept && !sel_invalid;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_mask
        assign load_mask[gi] = eff_bcast || onehot_bit(sel_ext, gi);
    end

    always_comb begin
        state_d      = state_q;
        dest_sel_d   = dest_sel_q;
        dest_bcast_d = dest_bcast_q;
        err_d        = 1'b0;
        if (accept) begin
            if (state_q == HEAD) begin
                dest_sel_d   = s_sel;
                dest_bcast_d = s_bcast;
                err_d        = sel_invalid;
                if (!s_last) state_d = PKT;
            end else if (s_last) begin
                state_d = HEAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HEAD;
            dest_sel_q   <= '0;
            dest_bcast_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dest_sel_q   <= dest_sel_d;
            dest_bcast_q <= dest_bcast_d;
            err_q        <= err_d;
        end
    end

    out_reg_slice #(
        .DATA_W(DATA_W),
        .N_OUT (N_OUT)
    ) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .load_data_i(s_data),
        .load_last_i(s_last),
        .load_mask_i(load_mask),
        .m_ready_i  (m_ready),
        .m_data_o   (m_data),
        .m_last_o   (m_last),
        .m_valid_o  (m_valid),
        .in_ready_o (s_ready),
        .occupied_o (occupied)
    );

    assign err_sel = err_q;
    assign busy    = (state_q == PKT) || occupied;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: transaction-level model plus directed vectors on an
// 8-channel instance, and a 6-channel instance for out-of-range selects.
module tb_stream_demux;

    localparam int N8 = 8;
    localparam int N6 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [7:0] s_data;
    logic [2:0] s_sel;
    logic       s_bcast, s_last, s_valid, s_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [7:0] m_valid, m_ready;
    logic       err_sel, busy;

    logic [7:0] t_data;
    logic [2:0] t_sel;
    logic       t_bcast, t_last, t_valid, t_ready;
    logic [7:0] t_m_data;
    logic       t_m_last;
    logic [5:0] t_m_valid, t_m_ready;
    logic       t_err_sel, t_busy;

    stream_demux #(.DATA_W(8), .N_OUT(N8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_sel(s_sel), .s_bcast(s_bcast), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .err_sel(err_sel), .busy(busy)
    );

    stream_demux #(.DATA_W(8), .N_OUT(N6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .s_data(t_data), .s_sel(t_sel), .s_bcast(t_bcast), .s_last(t_last),
        .s_valid(t_valid), .s_ready(t_ready),
        .m_data(t_m_data), .m_last(t_m_last), .m_valid(t_m_valid), .m_ready(t_m_ready),
        .err_sel(t_err_sel), .busy(t_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transaction-level model of the 8-channel instance.
    bit         started = 0;
    bit         md_in_pkt;
    logic [7:0] md_dest;
    bit         md_drop;
    logic [7:0] md_pend;
    logic [7:0] md_data;
    bit         md_last;
    bit         md_err;
    logic [7:0] md_next;
    logic [7:0] ch2_q[$];

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            started   = 1;
            md_in_pkt = 0;
            md_dest   = 8'h00;
            md_drop   = 0;
            md_pend   = 8'h00;
            md_data   = 8'h00;
            md_last   = 0;
            md_err    = 0;
        end else if (started) begin
            if (md_pend[2] && m_ready[2]) ch2_q.push_back(md_data);
            md_next = md_pend & ~m_ready;
            md_err  = 0;
            if (s_valid && ((md_pend & ~m_ready) == 8'h00)) begin
                if (!md_in_pkt) begin
                    md_drop   = !s_bcast && (int'(s_sel) >= N8);
                    md_dest   = s_bcast ? 8'hFF : (8'd1 << s_sel);
                    md_err    = md_drop;
                    md_in_pkt = !s_last;
                end else if (s_last) begin
                    md_in_pkt = 0;
                end
                if (!md_drop) begin
                    md_next = md_dest;
                    md_data = s_data;
                    md_last = s_last;
                end
            end
            md_pend = md_next;
        end
    end

    initial forever begin
        @(negedge clk);
        if (started && rst_n) begin
            chk("m_valid", 32'(m_valid), 32'(md_pend));
            if (md_pend != 8'h00) begin
                chk("m_data", 32'(m_data), 32'(md_data));
                chk("m_last", 32'(m_last), 32'(md_last));
            end
            chk("s_ready", 32'(s_ready), 32'((md_pend & ~m_ready) == 8'h00));
            chk("busy", 32'(busy), 32'(md_in_pkt || (md_pend != 8'h00)));
            chk("err_sel", 32'(err_sel), 32'(md_err));
        end
    end

    // Monitor for the 6-channel instance during the dropped packet.
    bit inv_phase = 0;
    int err6_cnt  = 0;
    int err6_cyc  = -1;
    int mv6_bad   = 0;

    initial forever begin
        @(negedge clk);
        if (inv_phase) begin
            if (t_err_sel === 1'b1) begin
                err6_cnt++;
                err6_cyc = cyc;
            end
            if (t_m_valid !== 6'h00) mv6_bad++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [2:0] sel, input logic bc, input logic last, input logic [7:0] d);
        int n;
        s_sel = sel; s_bcast = bc; s_last = last; s_data = d; s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (s_ready !== 1'b1) begin
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send8_timeout actual=stalled required=accept");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send6(input logic [2:0] sel, input logic bc, input logic last, input logic [7:0] d);
        int n;
        t_sel = sel; t_bcast = bc; t_last = last; t_data = d; t_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (t_ready !== 1'b1) begin
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send6_timeout actual=stalled required=accept");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        t_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int h_cyc;
        rst_n = 1'b0;
        s_data = 8'h00; s_sel = 3'd0; s_bcast = 1'b0; s_last = 1'b0; s_valid = 1'b0;
        m_ready = 8'hFF;
        t_data = 8'h00; t_sel = 3'd0; t_bcast = 1'b0; t_last = 1'b0; t_valid = 1'b0;
        t_m_ready = 6'h3F;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'h00);
        chk("rst_m_data", 32'(m_data), 32'h00);
        chk("rst_m_last", 32'(m_last), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err_sel), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h1);
        chk("rst6_s_ready", 32'(t_ready), 32'h1);
        step();

        // Unicast sweep
        for (int s = 0; s < 8; s++) begin
            send8(3'(s), 1'b0, 1'b1, 8'hA0 + 8'(s));
            @(negedge clk);
            chk("sweep_m_valid", 32'(m_valid), 32'(8'd1 << s));
            chk("sweep_m_data", 32'(m_data), 32'(8'hA0 + 8'(s)));
            chk("sweep_s_ready", 32'(s_ready), 32'h1);
            step();
        end

        // Packet lock: head on channel 3, later beats present sel 5
        send8(3'd3, 1'b0, 1'b0, 8'h31);
        @(negedge clk); chk("lock_b1", 32'(m_valid), 32'h08); step();
        send8(3'd5, 1'b0, 1'b0, 8'h32);
        @(negedge clk); chk("lock_b2", 32'(m_valid), 32'h08); step();
        send8(3'd5, 1'b0, 1'b0, 8'h33);
        @(negedge clk); chk("lock_b3", 32'(m_valid), 32'h08); step();
        send8(3'd5, 1'b0, 1'b1, 8'h34);
        @(negedge clk); chk("lock_b4", 32'(m_valid), 32'h08); chk("lock_b4_last", 32'(m_last), 32'h1); step();
        @(negedge clk); chk("lock_idle_busy", 32'(busy), 32'h0); step();
        send8(3'd5, 1'b0, 1'b1, 8'h55);
        @(negedge clk); chk("lock_next", 32'(m_valid), 32'h20); step();

        // Broadcast with staggered ready
        m_ready = 8'h00;
        send8(3'd0, 1'b1, 1'b1, 8'h5A);
        m_ready = 8'h0F;
        @(negedge clk);
        chk("bc_c0_valid", 32'(m_valid), 32'hFF);
        chk("bc_c0_data", 32'(m_data), 32'h5A);
        chk("bc_c0_ready", 32'(s_ready), 32'h0);
        step(); m_ready = 8'h00;
        @(negedge clk);
        chk("bc_c1_valid", 32'(m_valid), 32'hF0);
        chk("bc_c1_ready", 32'(s_ready), 32'h0);
        step();
        @(negedge clk);
        chk("bc_c2_valid", 32'(m_valid), 32'hF0);
        chk("bc_c2_data", 32'(m_data), 32'h5A);
        step(); m_ready = 8'hF0;
        @(negedge clk);
        chk("bc_c3_ready", 32'(s_ready), 32'h1);
        step(); m_ready = 8'hFF;
        @(negedge clk);
        chk("bc_retired", 32'(m_valid), 32'h00);
        step();

        // Back-pressure: m_ready[2] toggles, other channels ready
        m_ready = 8'hFB;
        ch2_q.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) send8(3'd2, 1'b0, (i == 15), 8'h10 + 8'(i));
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    m_ready[2] = ~m_ready[2];
                end
            end
        join
        m_ready = 8'hFF;
        repeat (3) step();
        chk("bp_count", 32'(ch2_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < ch2_q.size(); i++)
            chk("bp_data", 32'(ch2_q[i]), 32'(8'h10 + 8'(i)));

        // Throughput with channel 2 always ready
        ch2_q.delete();
        c0 = cyc;
        for (int i = 0; i < 16; i++) send8(3'd2, 1'b0, 1'b1, 8'h40 + 8'(i));
        chk("thru_cycles", 32'(cyc - c0), 32'd16);
        repeat (2) step();
        chk("thru_count", 32'(ch2_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < ch2_q.size(); i++)
            chk("thru_data", 32'(ch2_q[i]), 32'(8'h40 + 8'(i)));

        // Out-of-range select on the 6-channel instance
        inv_phase = 1;
        c0 = cyc;
        send6(3'd7, 1'b0, 1'b0, 8'h81);
        h_cyc = cyc;
        send6(3'd2, 1'b0, 1'b0, 8'h82);
        send6(3'd2, 1'b0, 1'b1, 8'h83);
        chk("inv_full_rate", 32'(cyc - c0), 32'd3);
        repeat (2) step();
        inv_phase = 0;
        chk("inv_err_pulses", 32'(err6_cnt), 32'd1);
        chk("inv_err_cycle", 32'(err6_cyc), 32'(h_cyc));
        chk("inv_no_valid", 32'(mv6_bad), 32'd0);
        chk("inv_idle_busy", 32'(t_busy), 32'h0);
        send6(3'd4, 1'b0, 1'b1, 8'h84);
        @(negedge clk);
        chk("inv_next_valid", 32'(t_m_valid), 32'h10);
        chk("inv_next_data", 32'(t_m_data), 32'h84);
        chk("inv_next_err", 32'(t_err_sel), 32'h0);
        step();

        // Reset mid-packet with the held beat stalled
        m_ready = 8'hFF;
        send8(3'd1, 1'b0, 1'b0, 8'h61);
        send8(3'd1, 1'b0, 1'b0, 8'h62);
        m_ready = 8'h00;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_valid", 32'(m_valid), 32'h02);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(m_valid), 32'h00);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_ready", 32'(s_ready), 32'h1);
        step();
        m_ready = 8'hFF;
        send8(3'd6, 1'b0, 1'b1, 8'h77);
        @(negedge clk);
        chk("post_rst_head", 32'(m_valid), 32'h40);
        chk("post_rst_data", 32'(m_data), 32'h77);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
